// File: rtl/fc_fetch_ctrl.sv
// Read sequencer for the FC weight/bias RAM: gathers a run of consecutive words into a
// zero-padded wide vector and hands it over with valid/ready. Loader writes preempt reads.
//
// state | meaning
// IDLE  | waiting for start; illegal word_count raises a one-cycle err
// FETCH | issuing one read per cycle, stalling on loader writes
// DRAIN | last read issued, waiting for its data
// HOLD  | vector complete, vec_valid high until accepted
module fc_fetch_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 120,
  parameter int CNT_W     = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [CNT_W-1:0]              word_count,
  output logic                          busy,
  output logic                          err,
  output logic [MAX_WORDS*DATA_W-1:0]   vec_out,
  output logic                          vec_valid,
  input  logic                          vec_ready,
  input  logic                          ld_we,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_din,
  output logic                          mem_we,
  output logic                          mem_re,
  input  logic [DATA_W-1:0]             mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t                            state_q, state_d;
  logic [ADDR_W-1:0]                 base_q, base_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [CNT_W-1:0]                  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]                  recv_cnt_q, recv_cnt_d;
  logic                              rd_pend_q, rd_pend_d;
  logic                              busy_q, busy_d;
  logic                              err_q, err_d;
  logic                              vec_valid_q, vec_valid_d;
  logic [MAX_WORDS-1:0][DATA_W-1:0]  vec_q, vec_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  issue_next;
  logic              wc_ok;

  // RAM port mux: a loader write always wins the port, which stalls the fetch
  always_comb begin
    rd_addr  = base_q + ADDR_W'(issue_cnt_q);
    mem_we   = ld_we & rst_n;
    mem_din  = ld_data;
    mem_addr = ld_we ? ld_addr : rd_addr;
    mem_re   = (state_q == S_FETCH) & ~ld_we & (issue_cnt_q < cnt_q);
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    vec_d       = vec_q;
    err_d       = 1'b0;
    rd_pend_d   = mem_re;
    issue_next  = issue_cnt_q + 1'b1;
    wc_ok       = (word_count != '0) && (word_count <= MAX_CNT);

    if (rd_pend_q && (recv_cnt_q < MAX_CNT)) begin
      vec_d[recv_cnt_q] = mem_dout;
      recv_cnt_d        = recv_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (wc_ok) begin
            base_d      = base_addr;
            cnt_d       = word_count;
            vec_d       = '0;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            state_d     = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (mem_re) begin
          issue_cnt_d = issue_next;
          if (issue_next == cnt_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_pend_q) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (vec_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    vec_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      rd_pend_q   <= rd_pend_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      vec_valid_q <= vec_valid_d;
      vec_q       <= vec_d;
    end
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign vec_valid = vec_valid_q;
  assign vec_out   = vec_q;

endmodule

// File: tb/tb_fc_fetch_ctrl.sv
// Directed bench for fc_fetch_ctrl with a behavioural sync-read RAM and a vector scoreboard.
module tb_fc_fetch_ctrl;

  localparam int VW = 120 * 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [13:0]     base_addr;
  logic [6:0]      word_count;
  logic            busy, err, vec_valid, vec_ready;
  logic [VW-1:0]   vec_out;
  logic            ld_we;
  logic [13:0]     ld_addr;
  logic [15:0]     ld_data;
  logic [13:0]     mem_addr;
  logic [15:0]     mem_din, mem_dout;
  logic            mem_we, mem_re;

  logic [15:0]     ram [0:16383];
  logic [15:0]     mdl [0:16383];
  logic [VW-1:0]   exp_q [$];
  logic [13:0]     addr_log [$];

  int n_checks = 0;
  int n_errors = 0;
  int re_cnt   = 0;
  int both_cnt = 0;

  fc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .err(err), .vec_out(vec_out),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_re(mem_re), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_re === 1'b1) begin
      re_cnt++;
      addr_log.push_back(mem_addr);
    end
    if (mem_re === 1'b1 && mem_we === 1'b1) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    int bad;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      bad = 0;
      for (int i = 119; i >= 0; i--) if (obs[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
      $error("FAIL %s: slot %0d observed %h expected %h", tag, bad,
             obs[bad*16 +: 16], exp[bad*16 +: 16]);
    end
  endtask

  task automatic load(input logic [13:0] a, input logic [15:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    mdl[a] = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic push_exp(input logic [13:0] base, input int cnt);
    logic [VW-1:0] v;
    logic [13:0]   a;
    v = '0;
    for (int i = 0; i < cnt; i++) begin
      a = base + 14'(i);
      v[i*16 +: 16] = mdl[a];
    end
    exp_q.push_back(v);
  endtask

  task automatic do_start(input logic [13:0] b, input logic [6:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int k);
    k = 0;
    while (vec_valid !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_vec_valid"}, vec_valid, 1);
    if (vec_valid === 1'b1) begin
      if (exp_q.size() == 0) check({tag, "_sb_nonempty"}, 0, 1);
      else check_vec({tag, "_vector"}, vec_out, exp_q.pop_front());
    end
  endtask

  initial begin
    int k;
    bit stable;
    int re_snap;
    logic [VW-1:0] snap;

    for (int i = 0; i < 16384; i++) mdl[i] = '0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    vec_ready = 1'b1; ld_we = 1'b1; ld_addr = '0; ld_data = 16'hDEAD;
    #12;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check_vec("rst_vec_out", vec_out, '0);
    ld_we = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // 1: full 120-word fetch
    for (int i = 0; i < 120; i++) load(14'(i), 16'(i + 1));
    push_exp(14'd0, 120);
    do_start(14'd0, 7'd120);
    wait_done(300, "t1", k);
    check("t1_latency", k, 121);
    check("t1_slot0", vec_out[15:0], 16'd1);
    check("t1_slot119", vec_out[VW-1 -: 16], 16'd120);
    check("t1_busy_in_hold", busy, 1);
    step();
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", vec_valid, 0);

    // 2: short fetch, consumer stalls for 10 cycles
    load(14'd200, 16'hAAAA);
    load(14'd201, 16'hBBBB);
    load(14'd202, 16'hCCCC);
    vec_ready = 1'b0;
    push_exp(14'd200, 3);
    do_start(14'd200, 7'd3);
    wait_done(50, "t2", k);
    check("t2_latency", k, 4);
    snap = vec_out;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (vec_valid !== 1'b1 || vec_out !== snap) stable = 1'b0;
    end
    check("t2_hold_stable", stable, 1);
    vec_ready = 1'b1;
    step();
    check("t2_valid_after", vec_valid, 0);
    check("t2_busy_after", busy, 0);

    // 3: loader writes interleaved with a fetch; 509 is overwritten before it is read
    for (int i = 0; i < 10; i++) load(14'(500 + i), 16'(16'h3000 + i));
    mdl[509] = 16'hBEEF;
    mdl[600] = 16'h6000;
    mdl[601] = 16'h6001;
    push_exp(14'd500, 10);
    do_start(14'd500, 7'd10);
    k = 0;
    while (vec_valid !== 1'b1 && k < 60) begin
      ld_we   = (k == 2 || k == 5 || k == 8);
      ld_addr = (k == 2) ? 14'd509 : (k == 5) ? 14'd600 : 14'd601;
      ld_data = (k == 2) ? 16'hBEEF : (k == 5) ? 16'h6000 : 16'h6001;
      step();
      k++;
    end
    ld_we = 1'b0;
    check("t3_vec_valid", vec_valid, 1);
    check("t3_latency", k, 14);
    if (exp_q.size() == 0) check("t3_sb_nonempty", 0, 1);
    else check_vec("t3_vector", vec_out, exp_q.pop_front());
    check("t3_no_we_re_overlap", both_cnt, 0);
    check("t3_ram600", ram[600], 16'h6000);
    check("t3_ram601", ram[601], 16'h6001);
    step();

    // 4: address wrap at top of RAM
    load(14'd16382, 16'h4A4A);
    load(14'd16383, 16'h4B4B);
    addr_log.delete();
    push_exp(14'd16382, 4);
    do_start(14'd16382, 7'd4);
    wait_done(50, "t4", k);
    check("t4_latency", k, 5);
    check("t4_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("t4_addr0", addr_log[0], 14'd16382);
      check("t4_addr1", addr_log[1], 14'd16383);
      check("t4_addr2", addr_log[2], 14'd0);
      check("t4_addr3", addr_log[3], 14'd1);
    end
    step();

    // 5: illegal counts, then start while busy
    re_snap = re_cnt;
    do_start(14'd0, 7'd0);
    check("t5_err_cnt0", err, 1);
    check("t5_busy_cnt0", busy, 0);
    step();
    check("t5_err_pulse0", err, 0);
    do_start(14'd0, 7'd121);
    check("t5_err_cnt121", err, 1);
    check("t5_busy_cnt121", busy, 0);
    step();
    check("t5_err_pulse121", err, 0);
    check("t5_no_reads", re_cnt, re_snap);
    for (int i = 0; i < 20; i++) load(14'(1000 + i), 16'(16'h5000 + i));
    push_exp(14'd1000, 20);
    do_start(14'd1000, 7'd20);
    step(); step(); step();
    do_start(14'd0, 7'd0);
    check("t5_busy_start_err", err, 0);
    check("t5_busy_start_busy", busy, 1);
    wait_done(100, "t5", k);
    step();

    // 6: reset in the middle of a fetch
    push_exp(14'd0, 120);
    do_start(14'd0, 7'd120);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_busy", busy, 0);
    check("t6_vec_valid", vec_valid, 0);
    check("t6_mem_re", mem_re, 0);
    check_vec("t6_vec_out", vec_out, '0);
    step();
    rst_n = 1'b1;
    step();
    push_exp(14'd0, 5);
    do_start(14'd0, 7'd5);
    wait_done(50, "t6_restart", k);
    check("t6_latency", k, 6);
    step();
    check("final_no_we_re_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
